// File: rtl/qcl_skid_buffer.sv
// -----------------------------------------------------------------------------
// qcl_skid_buffer
//
// Two-entry valid/ready skid buffer. It breaks the combinational ready path
// between downstream and upstream: ready_o depends only on registered state
// (and reset_i). Items accepted from upstream are presented downstream one
// cycle later. Order is preserved, with no loss or duplication.
//
// Parameters
//   width_p      payload width in bits (>= 1)
//   reset_val_p  value loaded into data_o / both storage registers on reset
//
// Ports
//   clk_i    in   1        clock, all state updates on rising edge
//   reset_i  in   1        synchronous, active-high reset
//   v_i      in   1        upstream valid
//   data_i   in   width_p  upstream payload
//   ready_o  out  1        upstream may transfer when high
//   v_o      out  1        downstream valid
//   data_o   out  width_p  downstream payload (main register)
//   ready_i  in   1        downstream accepts when high
//
// Build option
//   QCL_FPGA_INIT_EN  when defined, state and data registers get a power-up
//                     value (EMPTY, reset_val_p) so outputs are defined
//                     before the first reset. When undefined, registers have
//                     no initial value until the first reset edge.
// -----------------------------------------------------------------------------
module qcl_skid_buffer #(
    parameter int                 width_p     = 1,
    parameter logic [width_p-1:0] reset_val_p = '0
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               ready_i
);

    // Occupancy: EMPTY = nothing held, ONE = main valid, FULL = main + skid.
    // Skid-valid-without-main is not representable.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

`ifdef QCL_FPGA_INIT_EN
    state_e             state_q = EMPTY;
    logic [width_p-1:0] main_q  = reset_val_p;
    logic [width_p-1:0] skid_q  = reset_val_p;
`else
    state_e             state_q;
    logic [width_p-1:0] main_q;
    logic [width_p-1:0] skid_q;
`endif

    state_e             state_d;
    logic [width_p-1:0] main_d;
    logic [width_p-1:0] skid_d;

    logic skid_valid;
    logic in_xfer;
    logic out_xfer;

    assign skid_valid = (state_q == FULL);

    // ready_o is a pure function of registered state plus reset, so there is
    // no combinational path from ready_i or v_i.
    assign ready_o  = ~skid_valid & ~reset_i;
    assign v_o      = (state_q != EMPTY);
    assign data_o   = main_q;

    assign in_xfer  = v_i & ready_o;
    assign out_xfer = v_o & ready_i;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    state_d = ONE;
                    main_d  = data_i;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    main_d  = data_i;
                end else if (in_xfer) begin
                    // Downstream stalled: park the new item behind main.
                    state_d = FULL;
                    skid_d  = data_i;
                end else if (out_xfer) begin
                    // main keeps its last value; consumers ignore it while v_o=0
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // ready_o is low here, so v_i cannot cause a transfer.
                if (out_xfer) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= EMPTY;
            main_q  <= reset_val_p;
            skid_q  <= reset_val_p;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: tb/tb_qcl_skid_buffer.sv
// Bench for qcl_skid_buffer: directed scenarios followed by random traffic,
// all compared against a queue-based occupancy model of a 2-deep buffer.
module tb_qcl_skid_buffer;

    localparam int         W  = 8;
    localparam logic [7:0] RV = 8'hA5;

    logic         clk_i = 1'b0;
    logic         reset_i;
    logic         v_i;
    logic [W-1:0] data_i;
    logic         ready_o;
    logic         v_o;
    logic [W-1:0] data_o;
    logic         ready_i;

    int total = 0;
    int bad   = 0;

    // Reference model: queue of held items, head is what data_o must show.
    logic [7:0] q[$];
    logic [7:0] last_head;
    bit         mvalid = 0;
    bit         stall  = 0;
    logic [7:0] stall_data;

    qcl_skid_buffer #(
        .width_p    (W),
        .reset_val_p(RV)
    ) dut (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .v_i    (v_i),
        .data_i (data_i),
        .ready_o(ready_o),
        .v_o    (v_o),
        .data_o (data_o),
        .ready_i(ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, advance model.
    task automatic cyc(input logic rst, input logic v, input logic [7:0] d, input logic rdy);
        bit ein;
        bit eout;
        bit full;
        reset_i = rst;
        v_i     = v;
        data_i  = d;
        ready_i = rdy;
        @(negedge clk_i);
        full = (q.size() >= 2);
        if (mvalid) begin
            chk("ready_o", ready_o, {7'd0, !full && !rst});
            chk("v_o", v_o, {7'd0, q.size() > 0});
            chk("data_o", data_o, (q.size() > 0) ? q[0] : last_head);
            if (stall) begin
                chk("stall_v_o", v_o, 8'd1);
                chk("stall_data_o", data_o, stall_data);
            end
        end else if (rst) begin
            chk("ready_o_in_reset", ready_o, 8'd0);
        end
        stall      = mvalid && !rst && (q.size() > 0) && !rdy;
        stall_data = data_o;
        ein  = v && !full && !rst;
        eout = (q.size() > 0) && rdy && !rst;
        @(posedge clk_i);
        if (rst) begin
            q.delete();
            last_head = RV;
            mvalid    = 1;
        end else begin
            if (eout) last_head = q.pop_front();
            if (ein) q.push_back(d);
        end
        #1;
    endtask

    initial begin
        reset_i = 1'b1;
        v_i     = 1'b0;
        data_i  = '0;
        ready_i = 1'b0;
        #1;

        // Reset held two cycles; ready_o must rise the first cycle after.
        cyc(1, 1, 8'h99, 1);
        cyc(1, 1, 8'h98, 1);
        chk("reset_data", data_o, RV);
        chk("reset_v", v_o, 8'd0);
        cyc(0, 0, 8'h00, 0);

        // Back-to-back streaming with ready_i high.
        for (int i = 1; i <= 16; i++) cyc(0, 1, 8'(i), 1);
        chk("stream_last", data_o, 8'h10);
        cyc(0, 0, 8'h00, 1);

        // Backpressure: fill main and skid, third item blocked upstream.
        cyc(0, 1, 8'h11, 0);
        cyc(0, 1, 8'h22, 0);
        chk("bp_main", data_o, 8'h11);
        chk("bp_ready_low", ready_o, 8'd0);
        cyc(0, 1, 8'h33, 0);
        cyc(0, 1, 8'h33, 1);
        cyc(0, 1, 8'h33, 1);
        cyc(0, 0, 8'h00, 1);
        cyc(0, 0, 8'h00, 1);

        // Simultaneous in/out while holding one item.
        cyc(0, 1, 8'h44, 0);
        cyc(0, 1, 8'h55, 1);
        chk("simul_data", data_o, 8'h55);
        chk("simul_v", v_o, 8'd1);
        chk("simul_ready", ready_o, 8'd1);
        cyc(0, 0, 8'h00, 1);

        // Reset while full discards both items.
        cyc(0, 1, 8'h66, 0);
        cyc(0, 1, 8'h77, 0);
        cyc(1, 1, 8'h88, 1);
        chk("midrst_v", v_o, 8'd0);
        chk("midrst_data", data_o, RV);
        cyc(0, 0, 8'h00, 1);

        // Random traffic with occasional reset.
        for (int n = 0; n < 10000; n++) begin
            cyc(($urandom_range(0, 499) == 0),
                1'($urandom_range(0, 1)),
                8'($urandom),
                1'($urandom_range(0, 3) != 0 ? 1 : 0) & 1'($urandom_range(0, 1) | (n % 7 == 0 ? 1 : 0)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/qcl_skid_buffer.md
QCL_SKID_BUFFER -- requirements
Module: qcl_skid_buffer

Interface
REQ-001 SHALL have parameter width_p, default 1, payload width in bits (>=1).
REQ-002 SHALL have parameter reset_val_p, default 0, value data_o and both storage registers take on reset, truncated to width_p.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset_i  input  1  synchronous, active-high reset.
REQ-005 SHALL have port v_i  input  1  upstream valid.
REQ-006 SHALL have port data_i  input  width_p  upstream payload.
REQ-007 SHALL have port ready_o  output  1  upstream may transfer when high.
REQ-008 SHALL have port v_o  output  1  downstream valid.
REQ-009 SHALL have port data_o  output  width_p  downstream payload.
REQ-010 SHALL have port ready_i  input  1  downstream accepts when high.

Function
REQ-011 SHALL treat an input transfer as v_i & ready_o in a cycle, and an output transfer as v_o & ready_i.
REQ-012 SHALL hold two registers, main and skid, each with a valid bit; data_o = main data, v_o = main valid.
REQ-013 SHALL implement states EMPTY (none valid), ONE (main valid), FULL (main and skid valid); skid valid without main valid is illegal.
REQ-014 EMPTY: input transfer -> ONE with main <= data_i; else stay EMPTY.
REQ-015 ONE: input and output transfer -> ONE, main <= data_i; input only -> FULL, skid <= data_i; output only -> EMPTY; neither -> ONE, main unchanged.
REQ-016 FULL: output transfer -> ONE, main <= skid; no output transfer -> FULL, registers unchanged; v_i ignored in FULL.
REQ-017 SHALL drive ready_o = ~skid_valid & ~reset_i; no combinational path from ready_i or v_i to ready_o.
REQ-018 SHALL have one-cycle latency: data accepted in cycle N appears on data_o in cycle N+1 when in EMPTY or ONE.
REQ-019 SHALL sustain one transfer per cycle with ready_i held high, no bubbles.
REQ-020 SHALL preserve order; no item lost or duplicated under any v_i/ready_i pattern.
REQ-021 SHALL hold data_o and v_o stable while v_o & ~ready_i.
REQ-022 SHALL leave data_o at its last value when v_o low; consumers ignore it.

Reset
REQ-023 While reset_i high at a rising edge, state SHALL become EMPTY; main and skid data SHALL load reset_val_p; in-flight items discarded.
REQ-024 ready_o SHALL be 0 in any cycle reset_i is high and 1 in the first cycle after reset_i deasserts.
REQ-025 v_o SHALL be 0 in the cycle after a reset edge; reset mid-stream (any state) SHALL override all transfers in that cycle.

Configuration
REQ-026 Macro QCL_FPGA_INIT_EN SHALL, when defined, give all state and data registers a power-up initial value (valid bits 0, data reset_val_p), so outputs are defined before the first reset.
REQ-027 Without QCL_FPGA_INIT_EN, registers SHALL have no initial value; outputs undefined until the first reset edge; reset behaviour identical in both builds.

Verification
REQ-028 Reset: reset_i high 2 cycles, width_p=8, reset_val_p=8'hA5 -> v_o=0, data_o=8'hA5, ready_o=0 during reset and 1 on the first cycle after.
REQ-029 Streaming: ready_i=1, push 0x01..0x10 back-to-back -> data_o shows 0x01..0x10 one per cycle, each one cycle after acceptance, ready_o stays 1.
REQ-030 Backpressure: push 0x11,0x22,0x33 with ready_i=0 -> 0x11 in main, 0x22 in skid, ready_o=0 next cycle, 0x33 held by upstream; release ready_i -> output order 0x11,0x22,0x33, no gaps after release.
REQ-031 Simultaneous: in ONE with main=0x44, v_i=1 data_i=0x55 ready_i=1 -> next cycle data_o=0x55, v_o=1, state ONE.
REQ-032 Reset mid-operation: in FULL (0x66,0x77), assert reset_i with ready_i=1 -> next cycle v_o=0, data_o=reset_val_p, both items discarded.
REQ-033 Random: 10k cycles random v_i/ready_i, scoreboard -> every accepted item output once, in order; data_o stable while stalled.
